dsp_mac_sequencer: RTL
======================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
- REQ-001: Parameter LAT, default 3, is the number of clock edges from a sample entering the slice port to the matching P update.
  - It is fixed by the slice configuration: A1REG=B1REG=MREG=PREG=1, A0REG=B0REG=0, OPMODEREG=1, B_INPUT="DIRECT".
- REQ-002: CLK  in  1  single clock; all state changes on its rising edge.
- REQ-003: RST_N  in  1  synchronous, active-low reset.
- REQ-004: start  in  1  one-cycle job request; honoured only in IDLE.
- REQ-005: len  in  8  number of products in the job, sampled when start is honoured.
- REQ-006: sub  in  1  sampled with len; 1 = negative accumulate (P = P - M).
- REQ-007: s_valid / s_ready  in / out  1 / 1  sample-stream handshake.
- REQ-008: s_a, s_b  in  18 each  operand pair, transferred when s_valid and s_ready are both high.
- REQ-009: busy  out  1  high in every state except IDLE.
- REQ-010: done  out  1  one-cycle pulse marking job completion.
- REQ-011: result  out  48  accumulated value; held until the next done.
- REQ-012: dsp_A, dsp_B  out  18 each  registered operands to slice ports A and B.
- REQ-013: dsp_OPMODE  out  8  opmode to the slice.
- REQ-014: dsp_CEA, dsp_CEB, dsp_CEP  out  1 each  clock enables to the slice.
- REQ-015: dsp_CEM, dsp_CEOPMODE  out  1 each  constant 1.
- REQ-016: dsp_RSTP  out  1  active-high P reset to the slice.
- REQ-017: dsp_P  in  48  slice P output.

Function
- REQ-018: The FSM SHALL have exactly the states IDLE, RUN, DRAIN and DONE.
- REQ-019: IDLE: start with len>0 loads the remaining-count and sub, then goes to RUN; start with len=0 goes directly to DONE with result forced to 0.
- REQ-020: s_ready SHALL be high only in RUN.
- REQ-021: Each handshake SHALL decrement the remaining-count; the handshake that brings it to 0 moves the FSM to DRAIN.
- REQ-022: On a handshake at edge e:
  - dsp_A/dsp_B SHALL load s_a/s_b at e, and dsp_CEA/dsp_CEB SHALL be high for the cycle after e only.
- REQ-023: For the product handshaken at edge e, dsp_OPMODE SHALL be updated at edge e+1:
  - first product of the job: {sub,7'b0000001}, i.e. X=M, Z=0;
  - all later products: {sub,7'b0001001}, i.e. X=M, Z=P;
  - bit 5 (carry-in) is always 0.
- REQ-024: dsp_CEP SHALL be high exactly in the cycle ending at edge e+LAT for each handshaken product, and low otherwise.
- REQ-025: Gaps in s_valid SHALL be tolerated; no P update occurs for a gap cycle, and the sum is unaffected.
- REQ-026: DRAIN SHALL last until edge e_last+LAT, then enter DONE; e_last is the edge of the final handshake.
- REQ-027: DONE SHALL capture dsp_P into result at the edge that leaves DONE, which is edge e_last+LAT+1.
  - done SHALL be high for the one cycle after that edge, then the FSM returns to IDLE.
- REQ-028: For len=0, DONE SHALL last one cycle with result=0 and SHALL not touch the slice enables.
- REQ-029: start in any state other than IDLE SHALL be ignored; start in the cycle where done is high is also ignored.
- REQ-030: The arithmetic SHALL be the slice's own: result = ±Σ M_i, modulo 2^48; the controller adds no extra width handling.

Reset
- REQ-031: While RST_N=0 at an edge, the block SHALL load:
  - FSM=IDLE, remaining-count=0, sub=0;
  - s_ready=0, busy=0, done=0, result=0;
  - dsp_A=dsp_B=0, dsp_OPMODE=0;
  - dsp_CEA=dsp_CEB=dsp_CEP=0.
- REQ-032: dsp_RSTP SHALL be high while RST_N=0, so the slice P register clears.
- REQ-033: Reset asserted mid-job SHALL abandon the job with no done pulse; the first start after reset is honoured normally.

Verification
- REQ-034: len=3, sub=0, pairs (2,3),(4,5),(1,1) back-to-back -> done exactly 4 cycles after the last handshake edge; result=27.
- REQ-035: Same job with sub=1 -> result=48'hFFFF_FFFF_FFE5 (-27).
- REQ-036: Same job with s_valid low for 2 cycles between each pair -> result=27; dsp_CEP high for exactly 3 cycles in total.
- REQ-037: start with len=0 -> done on the cycle after DONE; result=0; dsp_CEA/CEB/CEP never high.
- REQ-038: start pulsed during RUN of a len=3 job -> ignored; one done; result=27; a following job with len=1, pair (7,6) -> result=42.
- REQ-039: RST_N low for 1 cycle after the 2nd handshake of a len=3 job -> no done; all outputs at reset values; a new len=1, pair (3,3) job -> result=9.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - job sequencer feeding a pipelined DSP slice for signed multiply-accumulate.
// One handshake per product; enables and opmode are timed to the slice register stages (LAT >= 2).
module dsp_mac_sequencer #(
  parameter int LAT = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic        sub,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [17:0] s_a,
  input  logic [17:0] s_b,
  output logic        busy,
  output logic        done,
  output logic [47:0] result,
  output logic [17:0] dsp_A,
  output logic [17:0] dsp_B,
  output logic [7:0]  dsp_OPMODE,
  output logic        dsp_CEA,
  output logic        dsp_CEB,
  output logic        dsp_CEP,
  output logic        dsp_CEM,
  output logic        dsp_CEOPMODE,
  output logic        dsp_RSTP,
  input  logic [47:0] dsp_P
);

  localparam int CW = $clog2(LAT) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic        sub_q, sub_d;
  logic        zero_q, zero_d;
  logic        first_q, first_d;
  logic        hs_first_q, hs_first_d;
  logic [CW-1:0] drain_q, drain_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic        done_q, done_d;
  logic [47:0] result_q, result_d;
  logic [17:0] a_q, a_d;
  logic [17:0] b_q, b_d;
  logic [7:0]  opmode_q, opmode_d;
  logic        hs;

  assign hs = s_valid && (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sub_d      = sub_q;
    zero_d     = zero_q;
    first_d    = first_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    result_d   = result_q;
    hs_first_d = hs && first_q;
    a_d        = hs ? s_a : a_q;
    b_d        = hs ? s_b : b_q;
    // Handshake flag travels one stage per slice register; stage 0 = CEA/CEB, last stage = CEP.
    vld_d      = vld_q;
    vld_d[0]   = hs;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    opmode_d   = vld_q[0] ? {sub_q, (hs_first_q ? 7'b0000001 : 7'b0001001)} : opmode_q;

    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          sub_d = sub;
          if (len == 8'd0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d  = 1'b0;
            rem_d   = len;
            first_d = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (hs) begin
          rem_d   = rem_q - 8'd1;
          first_d = 1'b0;
          if (rem_q == 8'd1) begin
            drain_d = CW'(LAT - 1);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - 1'b1;
      end
      DONE: begin
        result_d = zero_q ? 48'd0 : dsp_P;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      sub_q      <= 1'b0;
      zero_q     <= 1'b0;
      first_q    <= 1'b0;
      hs_first_q <= 1'b0;
      drain_q    <= '0;
      vld_q      <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      opmode_q   <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sub_q      <= sub_d;
      zero_q     <= zero_d;
      first_q    <= first_d;
      hs_first_q <= hs_first_d;
      drain_q    <= drain_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      result_q   <= result_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opmode_q   <= opmode_d;
    end
  end

  assign s_ready      = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign result       = result_q;
  assign dsp_A        = a_q;
  assign dsp_B        = b_q;
  assign dsp_OPMODE   = opmode_q;
  assign dsp_CEA      = vld_q[0];
  assign dsp_CEB      = vld_q[0];
  assign dsp_CEP      = vld_q[LAT-1];
  assign dsp_CEM      = 1'b1;
  assign dsp_CEOPMODE = 1'b1;
  assign dsp_RSTP     = ~RST_N;

endmodule
